// File: rtl/serial_comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
//   state_e   : controller states (IDLE, CMP, DONE)
//   verdict_t : recorded compare outcome, encoded with LT / EQ / GT
package serial_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0] verdict_t;

    localparam verdict_t LT = 2'd0;
    localparam verdict_t EQ = 2'd1;
    localparam verdict_t GT = 2'd2;

endpackage

// File: rtl/serial_comparator_cell.sv
// Single-bit magnitude compare cell (purely combinational).
//   a_bit, b_bit : the operand bits at the current position
//   msb          : high when this position is the sign bit
//   is_signed    : two's-complement mode
//   lt, gt       : this bit alone says A<B / A>B (both low when equal)
module bit_compare_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic msb,
    input  logic is_signed,
    output logic lt,
    output logic gt
);

    // A set sign bit means a negative value, so the sense flips at the MSB.
    logic invert;

    always_comb begin
        invert = msb & is_signed;
        lt     = invert ? (a_bit & ~b_bit) : (~a_bit & b_bit);
        gt     = invert ? (~a_bit & b_bit) : (a_bit & ~b_bit);
    end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial comparator: scans A and B one bit per clock, MSB first.
//   clk, rst               : clock, synchronous active-high reset
//   start_valid/ready, a, b, is_signed : request handshake and operands
//   res_valid/ready, L, E, G           : result handshake and verdict
//   busy                   : an operation is in progress (CMP or DONE)
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             L,
    output logic             E,
    output logic             G,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    verdict_t         verdict_q, verdict_d;
    logic             res_valid_q, res_valid_d;
    logic             l_q, l_d;
    logic             e_q, e_d;
    logic             g_q, g_d;
    logic             busy_q, busy_d;

    logic             cell_lt, cell_gt;
    verdict_t         bit_verdict;
    verdict_t         verdict_next;
    logic             finish;

    bit_compare_cell u_cell (
        .a_bit     (a_q[idx_q]),
        .b_bit     (b_q[idx_q]),
        .msb       (idx_q == IDX_MSB),
        .is_signed (sgn_q),
        .lt        (cell_lt),
        .gt        (cell_gt)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        verdict_d   = verdict_q;
        res_valid_d = res_valid_q;
        l_d         = l_q;
        e_d         = e_q;
        g_d         = g_q;
        busy_d      = busy_q;

        bit_verdict  = cell_lt ? LT : (cell_gt ? GT : EQ);
        // Only the first differing bit decides; once set the verdict sticks.
        verdict_next = (verdict_q == EQ) ? bit_verdict : verdict_q;
        finish       = ((EARLY_EXIT != 0) && (verdict_next != EQ)) || (idx_q == '0);

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d       = a;
                    b_d       = b;
                    sgn_d     = is_signed;
                    idx_d     = IDX_MSB;
                    verdict_d = EQ;
                    busy_d    = 1'b1;
                    state_d   = CMP;
                end
            end
            CMP: begin
                verdict_d = verdict_next;
                idx_d     = idx_q - 1'b1;
                if (finish) begin
                    res_valid_d = 1'b1;
                    l_d         = (verdict_next == LT);
                    e_d         = (verdict_next == EQ);
                    g_d         = (verdict_next == GT);
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    l_d         = 1'b0;
                    e_d         = 1'b0;
                    g_d         = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            verdict_q   <= EQ;
            res_valid_q <= 1'b0;
            l_q         <= 1'b0;
            e_q         <= 1'b0;
            g_q         <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            verdict_q   <= verdict_d;
            res_valid_q <= res_valid_d;
            l_q         <= l_d;
            e_q         <= e_d;
            g_q         <= g_d;
            busy_q      <= busy_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = res_valid_q;
    assign L           = l_q;
    assign E           = e_q;
    assign G           = g_q;
    assign busy        = busy_q;

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..64.
REQ-002 SHALL have parameter EARLY_EXIT, default 1: when 1, terminate on the first differing bit; when 0, always scan all bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL provide these ports, in this order:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- start_valid  input  1  operand request valid.
- start_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned compare.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts the result.
- L  output  1  A < B.
- E  output  1  A == B.
- G  output  1  A > B.
- busy  output  1  high in CMP or DONE.

Function
REQ-005 SHALL implement FSM states IDLE, CMP and DONE.
REQ-006 SHALL drive start_ready=1 only in IDLE.
REQ-007 SHALL accept a request on an edge where start_valid && start_ready, latch a, b and is_signed, load the bit index to WIDTH-1, and go to CMP.
REQ-008 SHALL, in CMP, evaluate one bit per clock, MSB first, decrementing the index; the counter width is $clog2(WIDTH).
REQ-009 SHALL, at the MSB in signed mode, invert the sense of the bit compare: a_msb=1, b_msb=0 gives L.
REQ-010 SHALL record the verdict from the first differing bit only; later bits never overwrite it.
REQ-011 SHALL, with EARLY_EXIT=1, go to DONE on the edge that evaluates the first differing bit i, so res_valid rises (WIDTH-i) edges after acceptance.
REQ-012 SHALL, with EARLY_EXIT=0 or equal operands, go to DONE after bit 0, so res_valid rises exactly WIDTH edges after acceptance.
REQ-013 SHALL, in DONE, hold res_valid=1 and exactly one of L/E/G high, all stable, until res_ready=1.
REQ-014 SHALL, on an edge where res_valid && res_ready, return to IDLE; start_ready rises on the following cycle (no accept/return overlap).
REQ-015 SHALL drive L=E=G=0 whenever res_valid=0.
REQ-016 SHALL ignore start_valid and changes on a, b or is_signed while busy=1.
REQ-017 SHALL register all outputs; no combinational path from inputs to outputs except start_ready, which decodes from state.

Reset
REQ-018 SHALL, on an edge with rst=1, enter IDLE with start_ready=1, res_valid=0, L=E=G=0, busy=0 and the index cleared.
REQ-019 SHALL let rst take priority over any handshake on the same edge; reset in CMP or DONE discards the operation and produces no result.

Structure
REQ-020 SHALL place the state enum (IDLE/CMP/DONE) and the verdict encoding constants (LT/EQ/GT) in package serial_comparator_pkg.
REQ-021 SHALL instantiate one sub-module, bit_compare_cell: purely combinational; inputs a_bit, b_bit, msb, is_signed; outputs lt and gt.

Verification (WIDTH=8)
REQ-022 Reset: rst=1 for 2 cycles, then 0 -> start_ready=1, busy=0, res_valid=0, L=E=G=0.
REQ-023 Unsigned early exit: a=0x80, b=0x7F, is_signed=0 -> G=1 exactly 1 edge after accept.
REQ-024 Signed MSB: a=0x80, b=0x7F, is_signed=1 -> L=1 exactly 1 edge after accept; with EARLY_EXIT=0, L=1 after 8 edges.
REQ-025 Equal with backpressure: a=b=0x5A, res_ready held 0 for 3 cycles after res_valid -> E=1 after 8 edges and held stable; start_ready=0 until the handshake edge, then start_ready=1 the next cycle.
REQ-026 LSB decision, ignored request: a=0x03, b=0x02 with a new start_valid pulse mid-CMP -> G=1 after 8 edges; the pulse is not accepted; operands are unchanged.
REQ-027 Mid-operation reset: a=0x01, b=0x00, rst=1 on the 3rd edge after accept -> IDLE next cycle; res_valid is never asserted for this request.
